sha3_scan_sequencer: RTL and testbench

- Job-level controller in front of one sha3_scanner instance (PROPER formulation).
- Accepts a host job (20-word block, threshold, chunk count) and drives the scanner's start/blobby/threshold inputs.
- Splits the nonce space into chunks of CHUNK_STRIDE, re-issues the scanner until a hit, exhaustion or abort.
- Returns one result record per job: absolute nonce and status; the 25-word hash is read directly from the scanner.

---
 rtl/sha3_scan_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_sha3_scan_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_scan_sequencer.sv
// Job-level controller for one sha3_scanner: splits a job's nonce space into chunks and
// re-issues the scanner until hit/exhaustion/abort. Optional: SHA3_SEQ_PERF_COUNTERS_EN.
`timescale 1ns/1ps
module sha3_scan_sequencer #(
  parameter int          NONCE_WORD    = 19,
  parameter logic [31:0] CHUNK_STRIDE  = 32'h8000_0000,
  parameter int          CHUNK_W       = 8,
  parameter int          START_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [19:0][31:0]    job_blobby,
  input  logic [63:0]          job_threshold,
  input  logic [CHUNK_W-1:0]   job_chunks,
  input  logic                 abort,
  output logic                 scn_start,
  output logic [19:0][31:0]    scn_blobby,
  output logic [63:0]          scn_threshold,
  input  logic                 scn_awaiting,
  input  logic                 scn_capture,
  input  logic [31:0]          scn_nonce,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [1:0]           res_status,
  output logic [31:0]          res_nonce,
  output logic [CHUNK_W-1:0]   res_chunk,
  output logic                 busy
`ifdef SHA3_SEQ_PERF_COUNTERS_EN
  ,
  output logic [63:0]          perf_busy_cycles,
  output logic [31:0]          perf_chunks,
  output logic [31:0]          perf_hits
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_ARM    = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;

  localparam logic [1:0] ST_FOUND     = 2'd0;
  localparam logic [1:0] ST_EXHAUSTED = 2'd1;
  localparam logic [1:0] ST_ABORTED   = 2'd2;
  localparam logic [1:0] ST_ERROR     = 2'd3;

  localparam int              TMO_W    = $clog2(START_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

  logic [2:0]         state_reg;
  logic [CHUNK_W-1:0] chunk_idx_reg;
  logic [CHUNK_W-1:0] chunks_reg;
  logic [31:0]        slot_reg;     // absolute nonce of the chunk currently issued
  logic               hit_reg;
  logic [TMO_W-1:0]   tmo_reg;

  logic load_job;
  logic last_chunk;
  logic advance;

  assign job_ready  = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign load_job   = (state_reg == S_IDLE) && job_valid;
  assign last_chunk = (chunk_idx_reg + CHUNK_W'(1)) == chunks_reg;
  assign advance    = (state_reg == S_DONE) && !hit_reg && !abort && !last_chunk;

  // Block words only change on job load or chunk advance, both at least one cycle before the start pulse.
  for (genvar gi = 0; gi < 20; gi++) begin : g_blobby
    if (gi == NONCE_WORD) begin : g_nonce
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        scn_blobby[gi] <= '0;
        else if (load_job) scn_blobby[gi] <= job_blobby[gi];
        else if (advance)  scn_blobby[gi] <= slot_reg + CHUNK_STRIDE;
      end
    end else begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        scn_blobby[gi] <= '0;
        else if (load_job) scn_blobby[gi] <= job_blobby[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      chunk_idx_reg <= '0;
      chunks_reg    <= '0;
      slot_reg      <= '0;
      hit_reg       <= 1'b0;
      tmo_reg       <= '0;
      scn_start     <= 1'b0;
      scn_threshold <= '0;
      res_valid     <= 1'b0;
      res_status    <= '0;
      res_nonce     <= '0;
      res_chunk     <= '0;
    end else begin
      scn_start <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (job_valid) begin
            scn_threshold <= job_threshold;
            chunks_reg    <= job_chunks;
            slot_reg      <= job_blobby[NONCE_WORD];
            chunk_idx_reg <= '0;
            hit_reg       <= 1'b0;
            res_nonce     <= '0;
            if (job_chunks == '0) begin
              state_reg  <= S_REPORT;
              res_valid  <= 1'b1;
              res_status <= ST_EXHAUSTED;
              res_chunk  <= '0;
            end else begin
              state_reg <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          scn_start <= 1'b1;
          tmo_reg   <= '0;
          state_reg <= S_ARM;
        end
        S_ARM: begin
          if (scn_awaiting) begin
            state_reg <= S_RUN;
          end else if (tmo_reg == TMO_LAST) begin
            state_reg  <= S_REPORT;
            res_valid  <= 1'b1;
            res_status <= ST_ERROR;
            res_chunk  <= chunk_idx_reg;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end
        S_RUN: begin
          // A capture coinciding with the awaiting fall is still taken.
          if (scn_capture && !hit_reg) begin
            hit_reg   <= 1'b1;
            res_nonce <= slot_reg + scn_nonce;
          end
          if (!scn_awaiting) state_reg <= S_DONE;
        end
        S_DONE: begin
          res_chunk <= chunk_idx_reg;
          if (hit_reg) begin
            state_reg  <= S_REPORT;
            res_valid  <= 1'b1;
            res_status <= ST_FOUND;
          end else if (abort) begin
            state_reg  <= S_REPORT;
            res_valid  <= 1'b1;
            res_status <= ST_ABORTED;
          end else if (last_chunk) begin
            state_reg  <= S_REPORT;
            res_valid  <= 1'b1;
            res_status <= ST_EXHAUSTED;
          end else begin
            chunk_idx_reg <= chunk_idx_reg + CHUNK_W'(1);
            slot_reg      <= slot_reg + CHUNK_STRIDE;
            state_reg     <= S_ISSUE;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef SHA3_SEQ_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles <= '0;
      perf_chunks      <= '0;
      perf_hits        <= '0;
    end else begin
      if (busy)                             perf_busy_cycles <= perf_busy_cycles + 64'd1;
      if (scn_start)                        perf_chunks      <= perf_chunks + 32'd1;
      if ((state_reg == S_DONE) && hit_reg) perf_hits        <= perf_hits + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha3_scan_sequencer.sv
// Directed bench for sha3_scan_sequencer with a small behavioural scanner model.
`timescale 1ns/1ps
module tb_sha3_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            job_valid, job_ready, abort, busy;
  logic [19:0][31:0] job_blobby, scn_blobby;
  logic [63:0]     job_threshold, scn_threshold;
  logic [7:0]      job_chunks, res_chunk;
  logic            scn_start, scn_awaiting, scn_capture;
  logic [31:0]     scn_nonce, res_nonce;
  logic            res_valid, res_ready;
  logic [1:0]      res_status;

  int checks = 0;
  int failures = 0;

  // scanner model configuration and observations
  int          n_starts;
  logic [31:0] start_nonce [0:7];
  logic [31:0] start_word0 [0:7];
  logic [63:0] start_thr   [0:7];
  bit          stable_ok;
  int          hit_chunk;
  logic [31:0] hit_off;
  int          cap_at;
  bit          never_await;
  bit          m_active;
  int          m_cnt, m_chunk;
  logic [19:0][31:0] prev_blob;
  logic [63:0] prev_thr;

  localparam logic [63:0] THR = 64'h0000_00FF_1234_5678;

  sha3_scan_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_blobby(job_blobby),
    .job_threshold(job_threshold), .job_chunks(job_chunks), .abort(abort),
    .scn_start(scn_start), .scn_blobby(scn_blobby), .scn_threshold(scn_threshold),
    .scn_awaiting(scn_awaiting), .scn_capture(scn_capture), .scn_nonce(scn_nonce),
    .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status),
    .res_nonce(res_nonce), .res_chunk(res_chunk), .busy(busy)
  );

  // Scanner model: awaiting rises 2 cycles after start, capture at cap_at, awaiting falls at 8.
  initial begin
    scn_awaiting = 1'b0; scn_capture = 1'b0; scn_nonce = '0;
    m_active = 1'b0; m_cnt = 0; m_chunk = 0;
    prev_blob = '0; prev_thr = '0;
    forever begin
      @(posedge clk); #1;
      scn_capture = 1'b0;
      if (!rst_n) begin
        m_active = 1'b0;
        scn_awaiting = 1'b0;
      end
      if (m_active) begin
        m_cnt++;
        if (m_cnt == 2) scn_awaiting = 1'b1;
        if (m_cnt == cap_at && m_chunk == hit_chunk) begin
          scn_capture = 1'b1;
          scn_nonce = hit_off;
        end
        if (m_cnt == 8) begin
          scn_awaiting = 1'b0;
          m_active = 1'b0;
        end
      end
      if (scn_start) begin
        if (scn_blobby !== prev_blob || scn_threshold !== prev_thr) stable_ok = 1'b0;
        if (n_starts < 8) begin
          start_nonce[n_starts] = scn_blobby[19];
          start_word0[n_starts] = scn_blobby[0];
          start_thr[n_starts]   = scn_threshold;
        end
        if (!never_await) begin
          m_active = 1'b1;
          m_cnt = 0;
          m_chunk = n_starts;
        end
        n_starts++;
      end
      prev_blob = scn_blobby;
      prev_thr  = scn_threshold;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic submit_job(input logic [31:0] base, input logic [7:0] chunks);
    n_starts = 0;
    stable_ok = 1'b1;
    for (int i = 0; i < 19; i++) job_blobby[i] = 32'hA500_0000 + 32'(i);
    job_blobby[19] = base;
    job_threshold = THR;
    job_chunks = chunks;
    @(posedge clk); #1;
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int k = 0;
    while (!res_valid && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout res_valid=%0b required=1", tag, res_valid);
    end
    $display("job %s: status=%0d nonce=%h chunk=%0d starts=%0d", tag, res_status, res_nonce, res_chunk, n_starts);
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({job_ready, busy, res_valid, scn_start} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl ready/busy/valid/start=%b required=1000", {job_ready, busy, res_valid, scn_start});
    end
    checks++;
    if (scn_blobby !== '0 || scn_threshold !== '0) begin
      failures++;
      $display("FAIL reset_scn blob19=%h thr=%h required=0", scn_blobby[19], scn_threshold);
    end
    checks++;
    if ({res_status, res_nonce, res_chunk} !== 42'd0) begin
      failures++;
      $display("FAIL reset_res got=%h required=0", {res_status, res_nonce, res_chunk});
    end
    rst_n = 1'b1;
    $display("reset: ready=%0b busy=%0b", job_ready, busy);
  endtask

  task automatic test_found_single();
    hit_chunk = 0; hit_off = 32'h25; cap_at = 4;
    submit_job(32'h0000_1000, 8'd1);
    checks++;
    if (busy !== 1'b1 || job_ready !== 1'b0) begin
      failures++;
      $display("FAIL found_busy busy=%0b ready=%0b required=1,0", busy, job_ready);
    end
    wait_result("found");
    checks++;
    if ({res_status, res_nonce, res_chunk} !== {2'd0, 32'h0000_1025, 8'd0}) begin
      failures++;
      $display("FAIL found_res got=%0d/%h/%0d required=0/00001025/0", res_status, res_nonce, res_chunk);
    end
    checks++;
    if (n_starts != 1 || start_nonce[0] !== 32'h0000_1000) begin
      failures++;
      $display("FAIL found_start starts=%0d nonce=%h required=1/00001000", n_starts, start_nonce[0]);
    end
    checks++;
    if (start_word0[0] !== 32'hA500_0000 || start_thr[0] !== THR || !stable_ok) begin
      failures++;
      $display("FAIL found_blob w0=%h thr=%h stable=%0b required=a5000000/%h/1", start_word0[0], start_thr[0], stable_ok, THR);
    end
    release_result();
    checks++;
    if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL found_idle ready=%0b valid=%0b required=1,0", job_ready, res_valid);
    end
  endtask

  task automatic test_wrap();
    hit_chunk = 1; hit_off = 32'h3; cap_at = 4;
    submit_job(32'h9000_0000, 8'd2);
    wait_result("wrap");
    checks++;
    if ({res_status, res_nonce, res_chunk} !== {2'd0, 32'h1000_0003, 8'd1}) begin
      failures++;
      $display("FAIL wrap_res got=%0d/%h/%0d required=0/10000003/1", res_status, res_nonce, res_chunk);
    end
    checks++;
    if (n_starts != 2 || start_nonce[1] !== 32'h1000_0000 || !stable_ok) begin
      failures++;
      $display("FAIL wrap_start starts=%0d nonce1=%h stable=%0b required=2/10000000/1", n_starts, start_nonce[1], stable_ok);
    end
    release_result();
  endtask

  task automatic test_exhaust();
    hit_chunk = -1; cap_at = 4;
    submit_job(32'h0000_0040, 8'd3);
    wait_result("exhaust");
    checks++;
    if ({res_status, res_nonce, res_chunk} !== {2'd1, 32'h0, 8'd2}) begin
      failures++;
      $display("FAIL exhaust_res got=%0d/%h/%0d required=1/00000000/2", res_status, res_nonce, res_chunk);
    end
    checks++;
    if (n_starts != 3 || start_nonce[2] !== 32'h0000_0040) begin
      failures++;
      $display("FAIL exhaust_starts starts=%0d nonce2=%h required=3/00000040", n_starts, start_nonce[2]);
    end
    release_result();
  endtask

  task automatic test_abort();
    int k = 0;
    hit_chunk = -1; cap_at = 4;
    submit_job(32'h0000_0000, 8'd4);
    while (!scn_awaiting && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    abort = 1'b1;
    wait_result("abort");
    checks++;
    if ({res_status, res_chunk} !== {2'd2, 8'd0} || n_starts != 1) begin
      failures++;
      $display("FAIL abort_res status=%0d chunk=%0d starts=%0d required=2/0/1", res_status, res_chunk, n_starts);
    end
    release_result();
    // abort still held: an idle job is accepted and a hit beats abort
    hit_chunk = 0; hit_off = 32'h5;
    submit_job(32'h0000_0000, 8'd1);
    wait_result("abort_idle");
    checks++;
    if ({res_status, res_nonce} !== {2'd0, 32'h5}) begin
      failures++;
      $display("FAIL abort_hit status=%0d nonce=%h required=0/00000005", res_status, res_nonce);
    end
    release_result();
    abort = 1'b0;
  endtask

  task automatic test_zero_chunks();
    hit_chunk = -1;
    submit_job(32'h1234_0000, 8'd0);
    wait_result("zero");
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({res_status, res_chunk} !== {2'd1, 8'd0} || n_starts != 0) begin
      failures++;
      $display("FAIL zero_res status=%0d chunk=%0d starts=%0d required=1/0/0", res_status, res_chunk, n_starts);
    end
    release_result();
  endtask

  task automatic test_capture_on_fall();
    hit_chunk = 0; hit_off = 32'h7; cap_at = 8;
    submit_job(32'h0000_0100, 8'd2);
    wait_result("cap_fall");
    checks++;
    if ({res_status, res_nonce, res_chunk} !== {2'd0, 32'h0000_0107, 8'd0} || n_starts != 1) begin
      failures++;
      $display("FAIL capfall_res got=%0d/%h/%0d starts=%0d required=0/00000107/0/1", res_status, res_nonce, res_chunk, n_starts);
    end
    release_result();
    cap_at = 4;
  endtask

  task automatic test_timeout();
    never_await = 1'b1;
    hit_chunk = -1;
    submit_job(32'h0000_0000, 8'd2);
    repeat (16) begin
      @(posedge clk); #1;
    end
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early res_valid=%0b required=0", res_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_status !== 2'd3 || res_chunk !== 8'd0) begin
      failures++;
      $display("FAIL timeout_res valid=%0b status=%0d chunk=%0d required=1/3/0", res_valid, res_status, res_chunk);
    end
    $display("job timeout: status=%0d starts=%0d", res_status, n_starts);
    release_result();
    never_await = 1'b0;
  endtask

  task automatic test_hold();
    logic [41:0] snap;
    int drift = 0;
    int starts0;
    hit_chunk = 0; hit_off = 32'h99; cap_at = 4;
    submit_job(32'h0000_0500, 8'd1);
    wait_result("hold");
    snap = {res_status, res_nonce, res_chunk};
    starts0 = n_starts;
    repeat (50) begin
      @(posedge clk); #1;
      if (!res_valid || {res_status, res_nonce, res_chunk} !== snap || scn_start) drift++;
    end
    checks++;
    if (drift != 0 || n_starts != starts0 || snap !== {2'd0, 32'h0000_0599, 8'd0}) begin
      failures++;
      $display("FAIL hold_stable drift=%0d starts=%0d res=%h required=0/%0d/%h", drift, n_starts, snap, starts0, {2'd0, 32'h0000_0599, 8'd0});
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int k = 0;
    hit_chunk = -1; cap_at = 4;
    submit_job(32'h0000_0000, 8'd4);
    while (!scn_awaiting && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({job_ready, res_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL resetmid_async ready/valid/busy=%b required=100", {job_ready, res_valid, busy});
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    hit_chunk = 0; hit_off = 32'h11;
    submit_job(32'h0000_2000, 8'd1);
    wait_result("after_reset");
    checks++;
    if ({res_status, res_nonce, res_chunk} !== {2'd0, 32'h0000_2011, 8'd0} || n_starts != 1) begin
      failures++;
      $display("FAIL resetmid_job got=%0d/%h/%0d starts=%0d required=0/00002011/0/1", res_status, res_nonce, res_chunk, n_starts);
    end
    release_result();
  endtask

  initial begin
    job_valid = 1'b0; job_blobby = '0; job_threshold = '0; job_chunks = '0;
    abort = 1'b0; res_ready = 1'b0;
    n_starts = 0; stable_ok = 1'b1; hit_chunk = -1; hit_off = '0; cap_at = 4; never_await = 1'b0;
    test_reset();
    test_found_single();
    test_wrap();
    test_exhaust();
    test_abort();
    test_zero_chunks();
    test_capture_on_fall();
    test_timeout();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
